// File: rtl/cv32e40p_recovery_pkg.sv
// cv32e40p_recovery_pkg
//   Shared types and sizes for the fault-recovery controller.
//   - rec_state_e : controller FSM states
//   - csr_ckpt_t  : PC / branch / CSR checkpoint captured when a fault is seen
//   - NUM_REGS    : registers restored from the golden source
//                   (NUM_GPR, or NUM_GPR+NUM_FPR when CV32E40P_RECOVERY_FP_EN is defined)
package cv32e40p_recovery_pkg;

    localparam int NUM_GPR = 32;
    localparam int NUM_FPR = 32;

`ifdef CV32E40P_RECOVERY_FP_EN
    localparam int NUM_REGS = NUM_GPR + NUM_FPR;
`else
    localparam int NUM_REGS = NUM_GPR;
`endif

    // Register-file addresses are 6 bits wide so the FP bank (32..63) fits.
    localparam int RF_AW = 6;

    // Address of the last even/odd pair that gets read.
    localparam logic [RF_AW-1:0] LAST_PAIR = RF_AW'(NUM_REGS - 2);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETBACK     = 3'd1,
        RF_RESTORE  = 3'd2,
        CSR_RESTORE = 3'd3,
        PC_RESTORE  = 3'd4,
        DONE        = 3'd5,
        FAIL        = 3'd6
    } rec_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        branch;
        logic [31:0] branch_addr;
        logic [6:0]  mstatus;
        logic [31:0] mie;
        logic [23:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mip;
        logic [5:0]  mcause;
    } csr_ckpt_t;

endpackage

// File: rtl/cv32e40p_recovery_ckpt.sv
// cv32e40p_recovery_ckpt
//   Checkpoint register: captures the live PC/CSR backup when capture_i is high,
//   otherwise holds. Cleared by reset.
// Ports
//   clk_i      in  clock
//   rst_i      in  asynchronous active-high reset
//   capture_i  in  load enable
//   ckpt_i     in  live backup values (csr_ckpt_t)
//   ckpt_o     out held checkpoint (csr_ckpt_t)
module cv32e40p_recovery_ckpt
    import cv32e40p_recovery_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      capture_i,
    input  csr_ckpt_t ckpt_i,
    output csr_ckpt_t ckpt_o
);

    csr_ckpt_t r_ckpt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ckpt <= '0;
        end else if (capture_i) begin
            r_ckpt <= ckpt_i;
        end
    end

    assign ckpt_o = r_ckpt;

endmodule

// File: rtl/cv32e40p_recovery_ctrl.sv
// cv32e40p_recovery_ctrl
//   Fault-recovery sequencer for the core. On fault_i it checkpoints PC/CSRs,
//   holds the core in setback, restores the register file pair-wise from a golden
//   copy (2-stage read/write pipeline), then presents CSRs and strobes a PC reload.
//   Faults during restore trigger a full retry; too many retries end in FAIL,
//   which only reset leaves.
// Configuration
//   CV32E40P_RECOVERY_FP_EN : also restore FP registers 32..63.
// Ports
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   fault_i                            fault level, sampled every cycle
//   backup_*_i                         live PC/CSR backup from the core
//   regfile_rdata_ra_i/rb_i            golden RF read data (combinational from raddr)
//   setback_o                          core setback
//   regfile_backup_o, raddr_ra/rb_o    golden RF read enable / addresses
//   recover_o                          core recovery mode
//   regfile_we/waddr/wdata_a_o, _b_o   restore write ports
//   recovery_*_o                       checkpoint values
//   pc_recover_o                       one-cycle PC reload strobe
//   busy_o, done_o, fail_o             active / completion pulse / sticky failure
module cv32e40p_recovery_ctrl
    import cv32e40p_recovery_pkg::*;
#(
    parameter int SETBACK_CYCLES = 4,
    parameter int MAX_RETRIES    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fault_i,

    input  logic [31:0]       backup_pc_i,
    input  logic              backup_branch_i,
    input  logic [31:0]       backup_branch_addr_i,
    input  logic [6:0]        backup_mstatus_i,
    input  logic [31:0]       backup_mie_i,
    input  logic [23:0]       backup_mtvec_i,
    input  logic [31:0]       backup_mscratch_i,
    input  logic [31:0]       backup_mepc_i,
    input  logic [31:0]       backup_mip_i,
    input  logic [5:0]        backup_mcause_i,

    input  logic [31:0]       regfile_rdata_ra_i,
    input  logic [31:0]       regfile_rdata_rb_i,

    output logic              setback_o,
    output logic              regfile_backup_o,
    output logic [RF_AW-1:0]  regfile_raddr_ra_o,
    output logic [RF_AW-1:0]  regfile_raddr_rb_o,
    output logic              recover_o,
    output logic              regfile_we_a_o,
    output logic [RF_AW-1:0]  regfile_waddr_a_o,
    output logic [31:0]       regfile_wdata_a_o,
    output logic              regfile_we_b_o,
    output logic [RF_AW-1:0]  regfile_waddr_b_o,
    output logic [31:0]       regfile_wdata_b_o,

    output logic [31:0]       recovery_pc_o,
    output logic              recovery_branch_o,
    output logic [31:0]       recovery_branch_addr_o,
    output logic [6:0]        recovery_mstatus_o,
    output logic [31:0]       recovery_mie_o,
    output logic [23:0]       recovery_mtvec_o,
    output logic [31:0]       recovery_mscratch_o,
    output logic [31:0]       recovery_mepc_o,
    output logic [31:0]       recovery_mip_o,
    output logic [5:0]        recovery_mcause_o,

    output logic              pc_recover_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o
);

    localparam int CNT_W = (SETBACK_CYCLES < 2) ? 1 : $clog2(SETBACK_CYCLES);
    localparam int RC_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETBACK_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRIES);

    rec_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RF_AW-1:0]  r_addr, w_addr_nxt;
    logic              r_rd_done, w_rd_done_nxt;
    logic              r_wr_vld, w_wr_vld_nxt;
    logic [RF_AW-1:0]  r_waddr;
    logic [31:0]       r_wdata_a, r_wdata_b;
    logic              r_retry, w_retry_nxt;
    logic [RC_W-1:0]   r_retry_cnt, w_retry_cnt_nxt;

    logic              w_capture;
    logic              w_rd;
    logic              w_fault_rec;
    csr_ckpt_t         w_ckpt_d, w_ckpt_q, w_ckpt_out;

    // ------------------------------------------------------------------
    // Checkpoint
    // ------------------------------------------------------------------
    assign w_ckpt_d = '{
        pc:          backup_pc_i,
        branch:      backup_branch_i,
        branch_addr: backup_branch_addr_i,
        mstatus:     backup_mstatus_i,
        mie:         backup_mie_i,
        mtvec:       backup_mtvec_i,
        mscratch:    backup_mscratch_i,
        mepc:        backup_mepc_i,
        mip:         backup_mip_i,
        mcause:      backup_mcause_i
    };

    cv32e40p_recovery_ckpt u_ckpt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (w_capture),
        .ckpt_i    (w_ckpt_d),
        .ckpt_o    (w_ckpt_q)
    );

    // FAIL drives every output except setback/fail to zero, checkpoint included.
    assign w_ckpt_out = (r_state == FAIL) ? '0 : w_ckpt_q;

    assign recovery_pc_o          = w_ckpt_out.pc;
    assign recovery_branch_o      = w_ckpt_out.branch;
    assign recovery_branch_addr_o = w_ckpt_out.branch_addr;
    assign recovery_mstatus_o     = w_ckpt_out.mstatus;
    assign recovery_mie_o         = w_ckpt_out.mie;
    assign recovery_mtvec_o       = w_ckpt_out.mtvec;
    assign recovery_mscratch_o    = w_ckpt_out.mscratch;
    assign recovery_mepc_o        = w_ckpt_out.mepc;
    assign recovery_mip_o         = w_ckpt_out.mip;
    assign recovery_mcause_o      = w_ckpt_out.mcause;

    // A fault while restoring counts as a retry; faults in SETBACK only restart it.
    assign w_fault_rec = fault_i && ((r_state == RF_RESTORE) ||
                                     (r_state == CSR_RESTORE) ||
                                     (r_state == PC_RESTORE));

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_addr_nxt       = r_addr;
        w_rd_done_nxt    = r_rd_done;
        w_wr_vld_nxt     = r_wr_vld;
        w_retry_nxt      = r_retry;
        w_retry_cnt_nxt  = r_retry_cnt;
        w_capture        = 1'b0;
        w_rd             = 1'b0;

        setback_o          = 1'b0;
        regfile_backup_o   = 1'b0;
        regfile_raddr_ra_o = '0;
        regfile_raddr_rb_o = '0;
        recover_o          = 1'b0;
        regfile_we_a_o     = 1'b0;
        regfile_waddr_a_o  = '0;
        regfile_wdata_a_o  = '0;
        regfile_we_b_o     = 1'b0;
        regfile_waddr_b_o  = '0;
        regfile_wdata_b_o  = '0;
        pc_recover_o       = 1'b0;
        busy_o             = 1'b0;
        done_o             = 1'b0;
        fail_o             = 1'b0;

        case (r_state)
            IDLE: begin
                if (fault_i) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = SETBACK;
                end
            end

            SETBACK: begin
                setback_o = 1'b1;
                busy_o    = 1'b1;
                if (fault_i) begin
                    w_cnt_nxt = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt   = RF_RESTORE;
                    w_addr_nxt    = '0;
                    w_rd_done_nxt = 1'b0;
                    w_wr_vld_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            RF_RESTORE: begin
                busy_o    = 1'b1;
                recover_o = 1'b1;
                // Read stage: one pair per cycle until the last pair has been read.
                w_rd             = !r_rd_done;
                regfile_backup_o = w_rd;
                if (w_rd) begin
                    regfile_raddr_ra_o = r_addr;
                    regfile_raddr_rb_o = r_addr + RF_AW'(1);
                    if (r_addr == LAST_PAIR) begin
                        w_rd_done_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + RF_AW'(2);
                    end
                end
                w_wr_vld_nxt = w_rd;
                // Write stage: registered pair from the previous read; x0 is never written.
                if (r_wr_vld) begin
                    regfile_we_a_o    = (r_waddr != '0);
                    regfile_waddr_a_o = r_waddr;
                    regfile_wdata_a_o = (r_waddr != '0) ? r_wdata_a : '0;
                    regfile_we_b_o    = 1'b1;
                    regfile_waddr_b_o = r_waddr + RF_AW'(1);
                    regfile_wdata_b_o = r_wdata_b;
                    if (r_rd_done) begin
                        w_state_nxt = CSR_RESTORE;
                    end
                end
            end

            CSR_RESTORE: begin
                busy_o      = 1'b1;
                recover_o   = 1'b1;
                w_state_nxt = PC_RESTORE;
            end

            PC_RESTORE: begin
                busy_o       = 1'b1;
                recover_o    = 1'b1;
                pc_recover_o = 1'b1;
                if (r_retry || fault_i) begin
                    w_state_nxt = SETBACK;
                    w_cnt_nxt   = CNT_LOAD;
                    w_retry_nxt = 1'b0;
                end else begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                done_o          = 1'b1;
                w_retry_nxt     = 1'b0;
                w_retry_cnt_nxt = '0;
                w_state_nxt     = IDLE;
            end

            FAIL: begin
                setback_o = 1'b1;
                fail_o    = 1'b1;
            end

            default: w_state_nxt = IDLE;
        endcase

        // Retry accounting overrides the transitions above when the budget is spent.
        if (w_fault_rec) begin
            if (r_retry_cnt == RC_MAX) begin
                w_state_nxt = FAIL;
            end else begin
                w_retry_cnt_nxt = r_retry_cnt + RC_W'(1);
                if (r_state != PC_RESTORE) begin
                    w_retry_nxt = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rd_done   <= 1'b0;
            r_wr_vld    <= 1'b0;
            r_waddr     <= '0;
            r_wdata_a   <= '0;
            r_wdata_b   <= '0;
            r_retry     <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_rd_done   <= w_rd_done_nxt;
            r_wr_vld    <= w_wr_vld_nxt;
            r_retry     <= w_retry_nxt;
            r_retry_cnt <= w_retry_cnt_nxt;
            if (w_rd) begin
                r_waddr   <= r_addr;
                r_wdata_a <= regfile_rdata_ra_i;
                r_wdata_b <= regfile_rdata_rb_i;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_recovery_ctrl.sv
// Testbench for cv32e40p_recovery_ctrl: per-cycle expected-output tables for the
// recovery sequences plus hand-written reset sequences.
module tb_cv32e40p_recovery_ctrl;
    import cv32e40p_recovery_pkg::*;

`ifdef CV32E40P_RECOVERY_FP_EN
    localparam int NR = 64;
`else
    localparam int NR = 32;
`endif
    localparam int SB = 4;
    localparam int RL = SB + NR/2 + 3;   // setback + RF + CSR + PC cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fault = 1'b0;
    logic [31:0] b_pc = '0, b_baddr = '0, b_mie = '0, b_mscratch = '0, b_mepc = '0, b_mip = '0;
    logic        b_branch = 1'b0;
    logic [6:0]  b_mstatus = '0;
    logic [23:0] b_mtvec = '0;
    logic [5:0]  b_mcause = '0;
    logic [31:0] rdata_ra, rdata_rb;

    logic        setback, rf_bk, recover, we_a, we_b, pcr, busy, done, fail;
    logic [5:0]  raddr_ra, raddr_rb, waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] r_pc, r_baddr, r_mie, r_mscratch, r_mepc, r_mip;
    logic        r_branch;
    logic [6:0]  r_mstatus;
    logic [23:0] r_mtvec;
    logic [5:0]  r_mcause;

    always #5 clk = ~clk;

    // Golden register file: value = 0xA5000000 | address.
    assign rdata_ra = 32'hA500_0000 | {26'd0, raddr_ra};
    assign rdata_rb = 32'hA500_0000 | {26'd0, raddr_rb};

    cv32e40p_recovery_ctrl #(.SETBACK_CYCLES(SB), .MAX_RETRIES(2)) dut (
        .clk_i(clk), .rst_i(rst), .fault_i(fault),
        .backup_pc_i(b_pc), .backup_branch_i(b_branch), .backup_branch_addr_i(b_baddr),
        .backup_mstatus_i(b_mstatus), .backup_mie_i(b_mie), .backup_mtvec_i(b_mtvec),
        .backup_mscratch_i(b_mscratch), .backup_mepc_i(b_mepc), .backup_mip_i(b_mip),
        .backup_mcause_i(b_mcause),
        .regfile_rdata_ra_i(rdata_ra), .regfile_rdata_rb_i(rdata_rb),
        .setback_o(setback), .regfile_backup_o(rf_bk),
        .regfile_raddr_ra_o(raddr_ra), .regfile_raddr_rb_o(raddr_rb),
        .recover_o(recover),
        .regfile_we_a_o(we_a), .regfile_waddr_a_o(waddr_a), .regfile_wdata_a_o(wdata_a),
        .regfile_we_b_o(we_b), .regfile_waddr_b_o(waddr_b), .regfile_wdata_b_o(wdata_b),
        .recovery_pc_o(r_pc), .recovery_branch_o(r_branch), .recovery_branch_addr_o(r_baddr),
        .recovery_mstatus_o(r_mstatus), .recovery_mie_o(r_mie), .recovery_mtvec_o(r_mtvec),
        .recovery_mscratch_o(r_mscratch), .recovery_mepc_o(r_mepc), .recovery_mip_o(r_mip),
        .recovery_mcause_o(r_mcause),
        .pc_recover_o(pcr), .busy_o(busy), .done_o(done), .fail_o(fail)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        bit fault;   // drive after sampling this cycle
        bit sb, busy, rec, pcr, done, fail, web;
    } vec_t;
    vec_t tab[$];
    logic [31:0] exp_pc;

    task automatic push(input bit f, input bit s, input bit b, input bit r,
                        input bit p, input bit d, input bit fl, input bit w);
        vec_t v;
        v.fault = f; v.sb = s; v.busy = b; v.rec = r;
        v.pcr = p; v.done = d; v.fail = fl; v.web = w;
        tab.push_back(v);
    endtask

    task automatic push_setback(input int n);
        for (int i = 0; i < n; i++) push(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    // RF phase (NR/2+1 cycles, writes from its 2nd cycle), CSR, PC.
    task automatic push_restore();
        for (int k = 0; k <= NR/2; k++) push(0, 0, 1, 1, 0, 0, 0, k >= 1);
        push(0, 0, 1, 1, 0, 0, 0, 0);
        push(0, 0, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic run_table(input string tn);
        for (int c = 0; c < tab.size(); c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d setback", tn, c), {31'd0, setback}, {31'd0, tab[c].sb});
            chk($sformatf("%s c%0d busy", tn, c), {31'd0, busy}, {31'd0, tab[c].busy});
            chk($sformatf("%s c%0d recover", tn, c), {31'd0, recover}, {31'd0, tab[c].rec});
            chk($sformatf("%s c%0d pc_recover", tn, c), {31'd0, pcr}, {31'd0, tab[c].pcr});
            chk($sformatf("%s c%0d done", tn, c), {31'd0, done}, {31'd0, tab[c].done});
            chk($sformatf("%s c%0d fail", tn, c), {31'd0, fail}, {31'd0, tab[c].fail});
            chk($sformatf("%s c%0d we_b", tn, c), {31'd0, we_b}, {31'd0, tab[c].web});
            if (tab[c].pcr) chk($sformatf("%s c%0d recovery_pc", tn, c), r_pc, exp_pc);
            fault = tab[c].fault;
        end
        fault = 1'b0;
    endtask

    // ---------------- write-port monitor ----------------
    int          nwr;
    logic [5:0]  last_wb;
    logic [31:0] seen [64];

    always @(negedge clk) begin
        if (we_a && !we_b) chk("we_a without we_b", 32'd1, 32'd0);
        if (we_b) begin
            chk("waddr_b pair", {26'd0, waddr_b}, {26'd0, waddr_a} + 32'd1);
            chk("wdata_b golden", wdata_b, 32'hA500_0000 | {26'd0, waddr_b});
            chk("we_a vs x0", {31'd0, we_a}, {31'd0, waddr_a != 6'd0});
            if (we_a) chk("wdata_a golden", wdata_a, 32'hA500_0000 | {26'd0, waddr_a});
            nwr++;
            last_wb = waddr_b;
            seen[waddr_b] = wdata_b;
        end
    end

    task automatic kick(input logic [31:0] pc);
        @(negedge clk);
        b_pc  = pc;
        fault = 1'b1;
    endtask

    initial begin
        nwr = 0;
        last_wb = '0;
        for (int i = 0; i < 64; i++) seen[i] = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("reset setback", {31'd0, setback}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset fail", {31'd0, fail}, 32'd0);
        chk("reset rf_backup", {31'd0, rf_bk}, 32'd0);
        chk("reset recovery_pc", r_pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", {31'd0, busy}, 32'd0);

        // ---- T1: clean recovery, fault in DONE ignored ----
        b_branch = 1'b1; b_baddr = 32'h0000_2200; b_mstatus = 7'h55; b_mie = 32'h0000_0888;
        b_mtvec = 24'h00_0101; b_mscratch = 32'h1234_5678; b_mepc = 32'h0000_1A3C;
        b_mip = 32'h0000_0080; b_mcause = 6'h2B;
        tab.delete();
        push_setback(SB);
        push_restore();
        push(1, 0, 0, 0, 0, 1, 0, 0);          // DONE, fault asserted there
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        exp_pc = 32'h0000_1A40;
        kick(32'h0000_1A40);
        run_table("t1");
        chk("t1 write count", nwr, NR/2);
        chk("t1 last waddr_b", {26'd0, last_wb}, NR - 1);
        chk("t1 x1", seen[1], 32'hA500_0001);
        chk("t1 x31", seen[31], 32'hA500_001F);
        chk("t1 pc", r_pc, 32'h0000_1A40);
        chk("t1 branch", {31'd0, r_branch}, 32'd1);
        chk("t1 branch_addr", r_baddr, 32'h0000_2200);
        chk("t1 mstatus", {25'd0, r_mstatus}, 32'h55);
        chk("t1 mie", r_mie, 32'h0000_0888);
        chk("t1 mtvec", {8'd0, r_mtvec}, 32'h0000_0101);
        chk("t1 mscratch", r_mscratch, 32'h1234_5678);
        chk("t1 mepc", r_mepc, 32'h0000_1A3C);
        chk("t1 mip", r_mip, 32'h0000_0080);
        chk("t1 mcause", {26'd0, r_mcause}, 32'h2B);

        // ---- T2: fault at addr 10 -> full redo, checkpoint unchanged ----
        nwr = 0;
        tab.delete();
        push_setback(SB);
        push_restore();
        push_setback(SB);
        push_restore();
        push(0, 0, 0, 0, 0, 1, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        tab[SB + 5].fault = 1'b1;              // RF cycle reading pair 10/11
        exp_pc = 32'h0000_3000;
        kick(32'h0000_3000);
        @(negedge clk);
        fault = 1'b0;
        b_pc  = 32'hDEAD_BEEF;
        chk("t2 c0 setback", {31'd0, setback}, 32'd1);
        tab.pop_front();
        run_table("t2");
        chk("t2 write count", nwr, NR);
        chk("t2 pc held", r_pc, 32'h0000_3000);

        // ---- T3: fault in SETBACK reloads the counter ----
        tab.delete();
        push_setback(3);
        tab[2].fault = 1'b1;
        push_setback(SB);
        push_restore();
        push(0, 0, 0, 0, 0, 1, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        exp_pc = 32'h0000_4000;
        kick(32'h0000_4000);
        run_table("t3");

        // ---- T4: three faults -> FAIL, only reset clears ----
        tab.delete();
        push_setback(SB); push_restore();
        push_setback(SB); push_restore();
        push_setback(SB); push_restore();
        while (tab.size() > 2*RL + 7) void'(tab.pop_back());
        tab[6].fault = 1'b1;
        tab[RL + 6].fault = 1'b1;
        tab[2*RL + 6].fault = 1'b1;
        for (int i = 0; i < 5; i++) push(i == 1, 1, 0, 0, 0, 0, 1, 0);
        exp_pc = 32'h0000_5000;
        kick(32'h0000_5000);
        run_table("t4");
        chk("t4 fail recovery_pc", r_pc, 32'd0);
        chk("t4 fail rf_backup", {31'd0, rf_bk}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t4 rst fail", {31'd0, fail}, 32'd0);
        chk("t4 rst setback", {31'd0, setback}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t4 idle after rst", {31'd0, setback | busy | fail}, 32'd0);

        // ---- T5: async reset mid RF_RESTORE ----
        kick(32'h0000_6000);
        @(negedge clk);
        fault = 1'b0;
        repeat (SB + 7) @(negedge clk);
        chk("t5 in rf recover", {31'd0, recover}, 32'd1);
        chk("t5 in rf backup", {31'd0, rf_bk}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5 rst recover", {31'd0, recover}, 32'd0);
        chk("t5 rst busy", {31'd0, busy}, 32'd0);
        chk("t5 rst rf_backup", {31'd0, rf_bk}, 32'd0);
        chk("t5 rst raddr_rb", {26'd0, raddr_rb}, 32'd0);
        chk("t5 rst we_b", {31'd0, we_b}, 32'd0);
        chk("t5 rst recovery_pc", r_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 idle", {31'd0, busy | setback | recover}, 32'd0);
        kick(32'h0000_7000);
        @(negedge clk);
        fault = 1'b0;
        chk("t5 restart setback", {31'd0, setback}, 32'd1);
        chk("t5 restart pc", r_pc, 32'h0000_7000);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
